// File: rtl/uart_tx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared definitions for the UART transmit path: FSM state
//               encodings, data width and the bit-period helper that the
//               RX side also reuses.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    localparam int c_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clock cycles per line bit, rounded to the nearest integer.
    function automatic int cycles_per_bit(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

    // Counter width able to hold 0..cpb-1; never narrower than one bit.
    function automatic int cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx_if
// Description : Valid/ready byte interface between the producer (core MMIO /
//               UART controller) and the UART transmitter.
//   data_in        byte to transmit          (master -> slave)
//   data_in_valid  producer has a byte       (master -> slave)
//   data_in_ready  transmitter takes it now  (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic [c_DATA_BITS-1:0] data_in;
    logic                   data_in_valid;
    logic                   data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );

endinterface

`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period counter. Counts 0..CYCLES_PER_BIT-1 and pulses
//               bit_done on the last count, then wraps to zero. restart
//               holds the count at zero.
//   clk       in  system clock
//   rst       in  asynchronous active-high reset
//   restart   in  hold/clear the counter
//   bit_done  out high during the final cycle of a bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
    import uart_tx_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int                 c_CNT_W = cnt_width(CYCLES_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CYCLES_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_bit_done;

    assign w_bit_done = (r_cnt == c_LAST);
    assign bit_done   = w_bit_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (restart || w_bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, one byte per frame, LSB first. 8N1 by
//               default; defining UART_TX_PARITY_EN inserts an even-parity
//               bit after data bit 7 (8E1). The line output is registered.
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   in_if       slave valid/ready byte interface (uart_tx_if)
//   serial_out  out  UART TX line, idle high
// Parameters  : CLK_FREQ (Hz), BAUD_RATE (bit/s)
// Macro       : UART_TX_PARITY_EN - enables the PARITY state
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  in_if,
    output logic      serial_out
);

    localparam int c_CYCLES_PER_BIT = cycles_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int c_IDX_W          = $clog2(c_DATA_BITS);

    uart_state_e              r_state;
    uart_state_e              w_state_next;
    logic [c_DATA_BITS-1:0]   r_shreg;
    logic [c_IDX_W-1:0]       r_bit_idx;
    logic                     r_ready;
    logic                     r_serial;
    logic                     w_serial_next;
    logic                     w_accept;
    logic                     w_bit_done;
    logic                     w_restart;
    logic                     w_last_bit;
`ifdef UART_TX_PARITY_EN
    logic                     r_parity;
`endif

    assign w_accept   = in_if.data_in_valid && r_ready;
    assign w_last_bit = (r_bit_idx == c_IDX_W'(c_DATA_BITS - 1));
    // Holding the counter clear while idle means every state entry starts at
    // count zero; all other state changes coincide with bit_done, which also
    // clears the counter.
    assign w_restart  = (r_state == ST_IDLE);

    assign in_if.data_in_ready = r_ready;
    assign serial_out          = r_serial;

    uart_baud_cnt #(
        .CYCLES_PER_BIT (c_CYCLES_PER_BIT)
    ) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .restart  (w_restart),
        .bit_done (w_bit_done)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_serial_next = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_serial_next = 1'b0;
                if (w_bit_done) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                w_serial_next = r_shreg[0];
                if (w_bit_done && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                w_serial_next = r_parity;
                if (w_bit_done) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------- output regs
    // The line is driven from the current state, so the start bit appears
    // one edge after the accept edge and every bit is delayed uniformly.
    // ready tracks the next state so it is high exactly while in IDLE, but
    // stays low through the reset period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_serial <= 1'b1;
            r_ready  <= 1'b0;
        end else begin
            r_serial <= w_serial_next;
            r_ready  <= (w_state_next == ST_IDLE);
        end
    end

    // --------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (w_accept) begin
            r_shreg <= in_if.data_in;
        end else if ((r_state == ST_DATA) && w_bit_done) begin
            r_shreg <= {1'b0, r_shreg[c_DATA_BITS-1:1]};
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^in_if.data_in;
        end
    end
`endif

    // Held at zero outside DATA so it restarts on every DATA entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_idx <= '0;
        end else if (r_state != ST_DATA) begin
            r_bit_idx <= '0;
        end else if (w_bit_done) begin
            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
        end
    end

endmodule

`default_nettype wire
